// File: rtl/rv32i_pkg.sv
// Shared RV32I writeback definitions: register-file geometry and the buffered
// result record used by the writeback arbiter and its load-result FIFO.
package rv32i_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Load-result FIFO for the writeback arbiter: DEPTH entries of {valid, rd, data},
// with per-entry visibility and a kill vector that clears valid bits in place.
module wb_fifo
   import rv32i_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  wb_entry_t                     push_ent,
   input  logic                          pop,
   input  logic [DEPTH-1:0]              kill,
   output wb_entry_t                     head,
   output logic [DEPTH-1:0]              ent_valid,
   output logic [DEPTH-1:0][REG_AW-1:0]  ent_rd,
   output logic [DEPTH-1:0][XLEN-1:0]    ent_data,
   output logic                          empty,
   output logic                          full
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic [DEPTH-1:0]             valid_q;
   logic [DEPTH-1:0]             valid_nxt;
   logic [DEPTH-1:0][REG_AW-1:0] rd_q;
   logic [DEPTH-1:0][XLEN-1:0]   data_q;
   logic [PW-1:0]                rptr;
   logic [PW-1:0]                wptr;
   logic [CW-1:0]                count;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   // The freshly written slot takes its valid from the push, overriding any kill.
   always_comb begin
      valid_nxt = valid_q & ~kill;
      if (pop)
         valid_nxt[rptr] = 1'b0;
      if (push)
         valid_nxt[wptr] = push_ent.valid;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
         rptr    <= '0;
         wptr    <= '0;
         count   <= '0;
      end else begin
         valid_q <= valid_nxt;
         if (push)
            wptr <= ptr_inc(wptr);
         if (pop)
            rptr <= ptr_inc(rptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         rd_q[wptr]   <= push_ent.rd;
         data_q[wptr] <= push_ent.data;
      end
   end

   assign head      = {valid_q[rptr], rd_q[rptr], data_q[rptr]};
   assign ent_valid = valid_q;
   assign ent_rd    = rd_q;
   assign ent_data  = data_q;
   assign empty     = (count == '0);
   assign full      = (count == CNT_FULL);

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results (strict priority) and buffered load results share one
// register-file write port. Forwarding of pending values is built only with WB_ARBITER_FWD_EN.
module wb_arbiter
   import rv32i_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid,
   input  logic [REG_AW-1:0] alu_rd,
   input  logic [XLEN-1:0]   alu_data,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic [XLEN-1:0]   mem_data,
   output logic [REG_AW-1:0] waddr,
   output logic [XLEN-1:0]   wdata,
   output logic              regwen,
   input  logic [REG_AW-1:0] q_addr1,
   input  logic [REG_AW-1:0] q_addr2,
   output logic              q_hit1,
   output logic              q_hit2,
   output logic [XLEN-1:0]   q_data1,
   output logic [XLEN-1:0]   q_data2
);

   logic                         alu_wr;
   logic                         push;
   logic                         pop;
   wb_entry_t                    push_ent;
   wb_entry_t                    head;
   logic [DEPTH-1:0]             kill;
   logic [DEPTH-1:0]             ent_valid;
   logic [DEPTH-1:0][REG_AW-1:0] ent_rd;
   logic [DEPTH-1:0][XLEN-1:0]   ent_data;
   logic                         empty;
   logic                         full;

   assign alu_wr    = alu_valid && (alu_rd != '0);
   assign mem_ready = !full;
   // rd 0 loads are handshaken but never stored.
   assign push      = mem_valid && mem_ready && (mem_rd != '0);
   assign pop       = !alu_valid && !empty;
   assign push_ent  = {!(alu_wr && (alu_rd == mem_rd)), mem_rd, mem_data};

   // A newer write to the same rd makes any older buffered value dead.
   always_comb begin
      kill = '0;
      for (int i = 0; i < DEPTH; i++)
         kill[i] = ent_valid[i] &&
                   ((alu_wr && (ent_rd[i] == alu_rd)) || (push && (ent_rd[i] == mem_rd)));
   end

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_ent  (push_ent),
      .pop       (pop),
      .kill      (kill),
      .head      (head),
      .ent_valid (ent_valid),
      .ent_rd    (ent_rd),
      .ent_data  (ent_data),
      .empty     (empty),
      .full      (full)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         regwen <= 1'b0;
         waddr  <= '0;
         wdata  <= '0;
      end else if (alu_valid) begin
         regwen <= alu_wr;
         if (alu_wr) begin
            waddr <= alu_rd;
            wdata <= alu_data;
         end
      end else if (pop) begin
         regwen <= head.valid;
         if (head.valid) begin
            waddr <= head.rd;
            wdata <= head.data;
         end
      end else begin
         regwen <= 1'b0;
      end
   end

`ifdef WB_ARBITER_FWD_EN
   // Buffered entries are newer than the output register, so they win.
   function automatic logic [XLEN:0] fwd_lookup(
      input logic [REG_AW-1:0]             qa,
      input logic                          wen,
      input logic [REG_AW-1:0]             wa,
      input logic [XLEN-1:0]               wd,
      input logic [DEPTH-1:0]              ev,
      input logic [DEPTH-1:0][REG_AW-1:0]  er,
      input logic [DEPTH-1:0][XLEN-1:0]    ed
   );
      logic [XLEN:0] r;
      r = '0;
      if (qa != '0) begin
         if (wen && (wa == qa))
            r = {1'b1, wd};
         for (int i = 0; i < DEPTH; i++)
            if (ev[i] && (er[i] == qa))
               r = {1'b1, ed[i]};
      end
      return r;
   endfunction

   always_comb begin
      {q_hit1, q_data1} = fwd_lookup(q_addr1, regwen, waddr, wdata, ent_valid, ent_rd, ent_data);
      {q_hit2, q_data2} = fwd_lookup(q_addr2, regwen, waddr, wdata, ent_valid, ent_rd, ent_data);
   end
`else
   logic unused_fwd;

   assign q_hit1     = 1'b0;
   assign q_hit2     = 1'b0;
   assign q_data1    = '0;
   assign q_data2    = '0;
   assign unused_fwd = ^{q_addr1, q_addr2, ent_data};
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, reset-under-load sequence, and random
// traffic compared against a queue-based reference model.
module tb_wb_arbiter;
   import rv32i_pkg::*;

   localparam int DEPTH = 2;
`ifdef WB_ARBITER_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              alu_valid;
   logic [REG_AW-1:0] alu_rd;
   logic [XLEN-1:0]   alu_data;
   logic              mem_valid;
   logic              mem_ready;
   logic [REG_AW-1:0] mem_rd;
   logic [XLEN-1:0]   mem_data;
   logic [REG_AW-1:0] waddr;
   logic [XLEN-1:0]   wdata;
   logic              regwen;
   logic [REG_AW-1:0] q_addr1;
   logic [REG_AW-1:0] q_addr2;
   logic              q_hit1;
   logic              q_hit2;
   logic [XLEN-1:0]   q_data1;
   logic [XLEN-1:0]   q_data2;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   wb_arbiter #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .alu_valid (alu_valid),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_rd    (mem_rd),
      .mem_data  (mem_data),
      .waddr     (waddr),
      .wdata     (wdata),
      .regwen    (regwen),
      .q_addr1   (q_addr1),
      .q_addr2   (q_addr2),
      .q_hit1    (q_hit1),
      .q_hit2    (q_hit2),
      .q_data1   (q_data1),
      .q_data2   (q_data2)
   );

   // fh/fd: forwarding seen this cycle; rw/wa/wd/rdy: outputs after the edge (wa/wd only if cw).
   typedef struct {
      bit        av;  bit [4:0] ard; bit [31:0] ad;
      bit        mv;  bit [4:0] mrd; bit [31:0] md;
      bit [4:0]  q1;  bit fh1;       bit [31:0] fd1;
      bit [4:0]  q2;  bit fh2;       bit [31:0] fd2;
      bit        rw;  bit cw;        bit [4:0]  wa;  bit [31:0] wd; bit rdy;
   } vec_t;

   typedef struct {
      bit        v;
      bit [4:0]  rd;
      bit [31:0] d;
   } ment_t;

   vec_t      tbl[23];
   ment_t     mq[$];
   bit        m_rw;
   bit [4:0]  m_wa;
   bit [31:0] m_wd;

   function automatic vec_t mk(input int av, input int ard, input int ad,
                               input int mv, input int mrd, input int md,
                               input int q1, input int fh1, input int fd1,
                               input int q2, input int fh2, input int fd2,
                               input int rw, input int cw, input int wa, input int wd,
                               input int rdy);
      vec_t v;
      v.av = (av != 0);  v.ard = 5'(ard);  v.ad = ad;
      v.mv = (mv != 0);  v.mrd = 5'(mrd);  v.md = md;
      v.q1 = 5'(q1);     v.fh1 = (fh1 != 0); v.fd1 = fd1;
      v.q2 = 5'(q2);     v.fh2 = (fh2 != 0); v.fd2 = fd2;
      v.rw = (rw != 0);  v.cw = (cw != 0); v.wa = 5'(wa); v.wd = wd; v.rdy = (rdy != 0);
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input bit av, input bit [4:0] ard, input bit [31:0] ad,
                        input bit mv, input bit [4:0] mrd, input bit [31:0] md,
                        input bit [4:0] q1, input bit [4:0] q2);
      alu_valid = av;  alu_rd = ard;  alu_data = ad;
      mem_valid = mv;  mem_rd = mrd;  mem_data = md;
      q_addr1   = q1;  q_addr2 = q2;
   endtask

   // Reference: newest pending value for a register (FIFO first, then the write port).
   task automatic fwd_ref(input bit [4:0] a, output bit h, output bit [31:0] d);
      h = 1'b0;
      d = '0;
      if (a != 0) begin
         for (int i = mq.size() - 1; i >= 0; i--)
            if (!h && mq[i].v && mq[i].rd == a) begin
               h = 1'b1;
               d = mq[i].d;
            end
         if (!h && m_rw && m_wa == a) begin
            h = 1'b1;
            d = m_wd;
         end
      end
   endtask

   task automatic model_step(input bit av, input bit [4:0] ard, input bit [31:0] ad,
                             input bit mv, input bit [4:0] mrd, input bit [31:0] md);
      bit    rdy;
      bit    do_pop;
      ment_t hd;
      rdy    = (mq.size() < DEPTH);
      do_pop = !av && (mq.size() > 0);
      hd     = '{v: 1'b0, rd: 5'd0, d: 32'd0};
      if (do_pop)
         hd = mq.pop_front();
      if (av && ard != 0)
         foreach (mq[i]) if (mq[i].rd == ard) mq[i].v = 1'b0;
      if (mv && rdy && mrd != 0) begin
         foreach (mq[i]) if (mq[i].rd == mrd) mq[i].v = 1'b0;
         mq.push_back('{v: !(av && ard == mrd), rd: mrd, d: md});
      end
      if (av) begin
         m_rw = (ard != 0);
         if (ard != 0) begin
            m_wa = ard;
            m_wd = ad;
         end
      end else if (do_pop) begin
         m_rw = hd.v;
         if (hd.v) begin
            m_wa = hd.rd;
            m_wd = hd.d;
         end
      end else begin
         m_rw = 1'b0;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      bit        h;
      bit [31:0] d;
      bit        av, mv;
      bit [4:0]  ard, mrd, q1, q2;
      bit [31:0] ad, md;

      tbl[0]  = mk(1,5,'h11,    0,0,0,       5,0,0,       0,0,0,       1,1,5,'h11,1);
      tbl[1]  = mk(0,0,0,       1,3,'hAA,    5,1,'h11,    3,0,0,       0,1,5,'h11,1);
      tbl[2]  = mk(0,0,0,       0,0,0,       3,1,'hAA,    5,0,0,       1,1,3,'hAA,1);
      tbl[3]  = mk(0,0,0,       0,0,0,       3,1,'hAA,    0,0,0,       0,1,3,'hAA,1);
      tbl[4]  = mk(1,1,'h101,   1,8,'h80,    8,0,0,       1,0,0,       1,1,1,'h101,1);
      tbl[5]  = mk(1,2,'h202,   1,9,'h90,    8,1,'h80,    9,0,0,       1,1,2,'h202,0);
      tbl[6]  = mk(1,4,'h404,   1,10,'hA0,   9,1,'h90,    2,1,'h202,   1,1,4,'h404,0);
      tbl[7]  = mk(0,0,0,       1,10,'hA0,   10,0,0,      8,1,'h80,    1,1,8,'h80,1);
      tbl[8]  = mk(0,0,0,       0,0,0,       9,1,'h90,    8,1,'h80,    1,1,9,'h90,1);
      tbl[9]  = mk(0,0,0,       0,0,0,       9,1,'h90,    0,0,0,       0,1,9,'h90,1);
      tbl[10] = mk(0,0,0,       1,7,'h77,    7,0,0,       0,0,0,       0,1,9,'h90,1);
      tbl[11] = mk(1,7,'h22,    0,0,0,       7,1,'h77,    0,0,0,       1,1,7,'h22,1);
      tbl[12] = mk(0,0,0,       0,0,0,       7,1,'h22,    0,0,0,       0,0,0,0,1);
      tbl[13] = mk(0,0,0,       0,0,0,       7,0,0,       0,0,0,       0,0,0,0,1);
      tbl[14] = mk(1,0,'h33,    1,0,'h44,    0,0,0,       0,0,0,       0,0,0,0,1);
      tbl[15] = mk(1,1,'h5,     1,11,'hB1,   0,0,0,       11,0,0,      1,1,1,'h5,1);
      tbl[16] = mk(0,0,0,       0,0,0,       11,1,'hB1,   1,1,'h5,     1,1,11,'hB1,1);
      tbl[17] = mk(1,12,'hC0,   1,12,'hD0,   12,0,0,      11,1,'hB1,   1,1,12,'hC0,1);
      tbl[18] = mk(0,0,0,       0,0,0,       12,1,'hC0,   0,0,0,       0,0,0,0,1);
      tbl[19] = mk(1,1,'h1,     1,13,'hE1,   13,0,0,      0,0,0,       1,1,1,'h1,1);
      tbl[20] = mk(1,2,'h2,     1,13,'hE2,   13,1,'hE1,   1,1,'h1,     1,1,2,'h2,0);
      tbl[21] = mk(0,0,0,       0,0,0,       13,1,'hE2,   2,1,'h2,     0,0,0,0,1);
      tbl[22] = mk(0,0,0,       0,0,0,       13,1,'hE2,   0,0,0,       1,1,13,'hE2,1);

      // Reset state
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 5'd5, 5'd3);
      repeat (2) @(posedge clk);
      #1;
      chk("reset regwen", 32'(regwen), 32'd0);
      chk("reset waddr", 32'(waddr), 32'd0);
      chk("reset wdata", wdata, 32'd0);
      chk("reset mem_ready", 32'(mem_ready), 32'd1);
      chk("reset q_hit1", 32'(q_hit1), 32'd0);
      chk("reset q_data1", q_data1, 32'd0);
      chk("reset q_hit2", 32'(q_hit2), 32'd0);
      rst = 1'b1;

      // Directed vector table
      for (int r = 0; r < 23; r++) begin
         drive(tbl[r].av, tbl[r].ard, tbl[r].ad, tbl[r].mv, tbl[r].mrd, tbl[r].md,
               tbl[r].q1, tbl[r].q2);
         #1;
         chk($sformatf("row%0d q_hit1", r), 32'(q_hit1), 32'(FWD & tbl[r].fh1));
         chk($sformatf("row%0d q_data1", r), q_data1, FWD ? tbl[r].fd1 : 32'd0);
         chk($sformatf("row%0d q_hit2", r), 32'(q_hit2), 32'(FWD & tbl[r].fh2));
         chk($sformatf("row%0d q_data2", r), q_data2, FWD ? tbl[r].fd2 : 32'd0);
         @(posedge clk);
         #1;
         chk($sformatf("row%0d regwen", r), 32'(regwen), 32'(tbl[r].rw));
         chk($sformatf("row%0d mem_ready", r), 32'(mem_ready), 32'(tbl[r].rdy));
         if (tbl[r].cw) begin
            chk($sformatf("row%0d waddr", r), 32'(waddr), 32'(tbl[r].wa));
            chk($sformatf("row%0d wdata", r), wdata, tbl[r].wd);
         end
      end

      // Reset while the FIFO is full and a write is on the port
      drive(1, 5'd1, 32'h1, 1, 5'd14, 32'h14E, 5'd0, 5'd0);
      @(posedge clk); #1;
      drive(1, 5'd2, 32'h2, 1, 5'd15, 32'h15F, 5'd0, 5'd0);
      @(posedge clk); #1;
      chk("full mem_ready", 32'(mem_ready), 32'd0);
      chk("full regwen", 32'(regwen), 32'd1);
      drive(0, 0, 0, 0, 0, 0, 5'd14, 5'd2);
      rst = 1'b0;
      #1;
      chk("midrst regwen", 32'(regwen), 32'd0);
      chk("midrst waddr", 32'(waddr), 32'd0);
      chk("midrst wdata", wdata, 32'd0);
      chk("midrst mem_ready", 32'(mem_ready), 32'd1);
      chk("midrst q_hit1", 32'(q_hit1), 32'd0);
      chk("midrst q_data1", q_data1, 32'd0);
      chk("midrst q_hit2", 32'(q_hit2), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         chk($sformatf("postrst%0d regwen", c), 32'(regwen), 32'd0);
         chk($sformatf("postrst%0d mem_ready", c), 32'(mem_ready), 32'd1);
         chk($sformatf("postrst%0d q_hit1", c), 32'(q_hit1), 32'd0);
      end

      // Random traffic against the reference model
      mq.delete();
      m_rw = 1'b0;
      m_wa = '0;
      m_wd = '0;
      for (int c = 0; c < 3000; c++) begin
         av  = ($urandom_range(0, 99) < 45);
         ard = 5'($urandom_range(0, 7));
         ad  = $urandom;
         mv  = ($urandom_range(0, 99) < 60);
         mrd = 5'($urandom_range(0, 7));
         md  = $urandom;
         q1  = 5'($urandom_range(0, 7));
         q2  = 5'($urandom_range(0, 7));
         drive(av, ard, ad, mv, mrd, md, q1, q2);
         #1;
         fwd_ref(q1, h, d);
         chk($sformatf("rnd%0d q_hit1", c), 32'(q_hit1), 32'(FWD & h));
         chk($sformatf("rnd%0d q_data1", c), q_data1, FWD ? d : 32'd0);
         fwd_ref(q2, h, d);
         chk($sformatf("rnd%0d q_hit2", c), 32'(q_hit2), 32'(FWD & h));
         chk($sformatf("rnd%0d q_data2", c), q_data2, FWD ? d : 32'd0);
         model_step(av, ard, ad, mv, mrd, md);
         @(posedge clk);
         #1;
         chk($sformatf("rnd%0d regwen", c), 32'(regwen), 32'(m_rw));
         chk($sformatf("rnd%0d mem_ready", c), 32'(mem_ready), 32'(mq.size() < DEPTH));
         if (m_rw) begin
            chk($sformatf("rnd%0d waddr", c), 32'(waddr), 32'(m_wa));
            chk($sformatf("rnd%0d wdata", c), wdata, m_wd);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
